axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
AXI3 slave (responder) that services read and write transactions from an AXI master, such as the CPU's SRAM-like-to-AXI bridge, out of a single-port synchronous SRAM. It sits on the slave side of the CPU AXI interface, as the memory/device model for the bench and as the on-chip RAM for SoC integration. It supports single-beat and FIXED/INCR bursts, arbitrates between the read and write channels, and serialises all traffic onto one RAM port.

Parameters:
ADDR_W, 16, RAM word-address width (RAM depth = 2^ADDR_W words of 32 bits)
ID_W, 4, AXI ID width

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
arid  in  ID_W  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1
arsize  in  3  bytes per beat = 1<<arsize; must be 0..2
arburst  in  2  00 FIXED, 01 INCR, others are treated as INCR
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_W  read ID (= latched arid)
rdata  out  32  read data
rresp  out  2  always 2'b00
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  ID_W  write ID
awaddr  in  32  write byte address
awlen  in  8  beats-1
awsize  in  3  bytes per beat
awburst  in  2  as arburst
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  32  write data
wstrb  in  4  byte strobes
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_W  write ID (= latched awid)
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
ram_en  out  1  RAM access enable
ram_we  out  4  RAM byte write enables (0 = read)
ram_addr  out  ADDR_W  RAM word address = byte_addr[ADDR_W+1:2]
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after a ram_en read

Behaviour:
- Reset (resetn low, any cycle, including mid-burst): FSM goes to IDLE. arready, awready, wready, rvalid, bvalid, rlast, ram_en and ram_we are 0; rdata, rid, bid and bresp are 0; the priority flag selects read. In-flight transactions are dropped with no response.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_RESP.
- IDLE arbitration: arready = IDLE && arvalid && (!awvalid || prio_rd); awready = IDLE && awvalid && (!arvalid || !prio_rd). Both ready signals are combinational from state, valid and flag. On every grant, prio flips toward the other channel, so simultaneous requests alternate fairly.
- AR handshake: latch id, addr, len, size, burst; beat counter cnt=0; go to RD_REQ.
- RD_REQ: ram_en=1, ram_we=0, ram_addr from the current addr; go to RD_WAIT.
- RD_WAIT: capture ram_rdata into the rdata register; set rvalid=1 and rlast=(cnt==len); go to RD_RESP. Each beat takes 3 cycles minimum from request.
- RD_RESP: rid/rdata/rlast are held stable while rvalid && !rready. On the handshake, rvalid drops. If rlast, go to IDLE. Otherwise cnt++, advance addr, go to RD_REQ.
- Address advance: INCR adds (1<<size) to the 32-bit byte address (wraps mod 2^32). FIXED leaves the address unchanged. ram_addr takes bits [ADDR_W+1:2], so addresses beyond the RAM alias modulo its depth. Narrow reads return the full word; the master selects byte lanes.
- AW handshake: latch id, addr, len, size, burst; cnt=0; err=0; go to WR_DATA.
- WR_DATA: wready=1. On a W handshake, in the same cycle: ram_en=1, ram_we=wstrb, ram_wdata=wdata, ram_addr from the current addr. Set err if wlast != (cnt==len). If cnt==len, go to WR_RESP. Otherwise cnt++ and advance addr. A write with wstrb=0 performs no RAM update and still counts as a beat.
- The burst ends on the beat count only; wlast never shortens or extends a burst.
- WR_RESP: bvalid=1; bid=latched id; bresp = err ? 2'b10 : 2'b00. Hold until bready, then go to IDLE.
- The block never asserts arready/awready outside IDLE. It has one outstanding transaction at a time. Read-after-write ordering follows grant order.
- arsize > 2 is unsupported, and its behaviour is undefined (the bench does not drive it).

Test Plan:
- Single read: after the RAM word at 0x10 is preloaded with 0xDEADBEEF, drive AR araddr=0x40, arid=0, arlen=0, arsize=2 with rready=1 → the R beat arrives ≥3 cycles after the AR handshake with rdata=0xDEADBEEF, rid=0, rlast=1, rresp=00.
- Single write: drive AW awaddr=0x44, awid=1, awlen=0, and W wdata=0x12345678, wstrb=4'b0011, wlast=1 → RAM word 0x11 has only its low 2 bytes updated; bvalid with bid=1, bresp=00; reading back gives the old upper half with 0x5678 in the low half.
- INCR burst read: araddr=0x100, arlen=3, arsize=2, with rready toggled 1/0 every cycle → 4 beats from words 0x40–0x43 in order, rlast only on beat 4, and rdata stable during stalls.
- Arbitration: arvalid and awvalid asserted together in the same cycle, twice back-to-back → read granted first, then write, then read (alternation observed).
- wlast error: awlen=1 but wlast=1 on beat 1 → 2 RAM writes happen; bresp=2'b10 after the second beat.
- Reset mid-burst: resetn pulled low during RD_RESP of an arlen=7 burst → rvalid=0 immediately, arready returns in IDLE after resetn rises, and a new single read completes correctly.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3 slave that services one read or write transaction at a time from a
//   single-port synchronous SRAM. It supports single beats and FIXED/INCR
//   bursts. A priority flag alternates grants between the AR and AW channels,
//   so simultaneous requests are served fairly.
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   ar* / r*                       AXI read address and read data channels
//   aw* / w* / b*                  AXI write address, data and response channels
//   ram_en, ram_we, ram_addr,      single-port RAM interface; ram_rdata is
//   ram_wdata, ram_rdata           valid the cycle after a ram_en read
module axi_sram_slave #(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,

    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,

    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t            state, state_nxt;

    logic [ID_W-1:0]   id_q;
    logic [31:0]       addr_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err_q;
    logic              prio_rd_q;
    logic [31:0]       rdata_q;
    logic              rlast_q;

    logic              ar_hs;
    logic              aw_hs;
    logic              r_hs;
    logic              w_hs;
    logic              last_beat;

    // FIXED keeps the address; every other burst encoding steps by the beat size.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] r;
        if (burst == 2'b00)
            r = a;
        else
            r = a + (32'd1 << size);
        return r;
    endfunction

    assign ar_hs     = arvalid && arready;
    assign aw_hs     = awvalid && awready;
    assign r_hs      = rvalid && rready;
    assign w_hs      = wvalid && wready;
    assign last_beat = (cnt_q == len_q);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ar_hs)
                    state_nxt = RD_REQ;
                else if (aw_hs)
                    state_nxt = WR_DATA;
            end
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = RD_RESP;
            RD_RESP: begin
                if (r_hs)
                    state_nxt = rlast_q ? IDLE : RD_REQ;
            end
            WR_DATA: begin
                // The beat count alone ends the burst; wlast only flags errors.
                if (w_hs && last_beat)
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (bready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        arready   = (state == IDLE) && arvalid && (!awvalid || prio_rd_q);
        awready   = (state == IDLE) && awvalid && (!arvalid || !prio_rd_q);
        wready    = (state == WR_DATA);
        rvalid    = (state == RD_RESP);
        bvalid    = (state == WR_RESP);
        rid       = id_q;
        bid       = id_q;
        rdata     = rdata_q;
        rresp     = 2'b00;
        rlast     = rlast_q && (state == RD_RESP);
        bresp     = err_q ? 2'b10 : 2'b00;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = addr_q[ADDR_W+1:2];
        ram_wdata = wdata;
        if (state == RD_REQ) begin
            ram_en = 1'b1;
        end else if (state == WR_DATA && wvalid) begin
            ram_en = 1'b1;
            ram_we = wstrb;
        end
    end

    // Transaction context, beat counter and read-data holding register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            prio_rd_q <= 1'b1;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        id_q      <= arid;
                        addr_q    <= araddr;
                        len_q     <= arlen;
                        size_q    <= arsize;
                        burst_q   <= arburst;
                        cnt_q     <= '0;
                        prio_rd_q <= 1'b0;
                    end else if (aw_hs) begin
                        id_q      <= awid;
                        addr_q    <= awaddr;
                        len_q     <= awlen;
                        size_q    <= awsize;
                        burst_q   <= awburst;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        prio_rd_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    rdata_q <= ram_rdata;
                    rlast_q <= last_beat;
                end
                RD_RESP: begin
                    if (r_hs && !rlast_q) begin
                        cnt_q  <= cnt_q + 8'd1;
                        addr_q <= next_addr(addr_q, size_q, burst_q);
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (wlast != last_beat)
                            err_q <= 1'b1;
                        if (!last_beat) begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= next_addr(addr_q, size_q, burst_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//   Directed bench for axi_sram_slave with a behavioural synchronous RAM.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   2 time units after the rising edge.
module tb_axi_sram_slave;

    localparam int ADDR_W = 16;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [ID_W-1:0]   arid = '0;
    logic [31:0]       araddr = '0;
    logic [7:0]        arlen = '0;
    logic [2:0]        arsize = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [ID_W-1:0]   awid = '0;
    logic [31:0]       awaddr = '0;
    logic [7:0]        awlen = '0;
    logic [2:0]        awsize = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wlast = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM with a preload port owned by the bench
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [31:0]       pl_data = '0;
    int                wr_count = 0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            if (|ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b])
                        mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                wr_count <= wr_count + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [1:0] burst);
        int n;
        arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = burst;
        arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin @(posedge clk); #2; n++; end
        check_val("ar_grant", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [ID_W-1:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [1:0] burst);
        int n;
        awid = id; awaddr = a; awlen = len; awsize = 3'd2; awburst = burst;
        awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 50) begin @(posedge clk); #2; n++; end
        check_val("aw_grant", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        #1;
        n = 0;
        while (!wready && n < 50) begin @(posedge clk); #2; n++; end
        check_val("w_ready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    // Accept one R beat with rready held high; lat counts edges up to the handshake.
    task automatic recv_r(output logic [31:0] d, output logic [ID_W-1:0] id,
                          output logic last, output logic [1:0] resp, output int lat);
        int n;
        rready = 1'b1;
        #1;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #2; n++; end
        check_val("r_valid", 32'(rvalid), 32'd1);
        d = rdata; id = rid; last = rlast; resp = rresp; lat = n + 1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic recv_b(output logic [ID_W-1:0] id, output logic [1:0] resp);
        int n;
        bready = 1'b1;
        #1;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #2; n++; end
        check_val("b_valid", 32'(bvalid), 32'd1);
        id = bid; resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    logic [31:0]     d;
    logic [ID_W-1:0] id;
    logic            last;
    logic [1:0]      resp;
    int              lat;
    int              wc0;

    initial begin
        // Preload while reset is held
        preload(16'h0010, 32'hDEADBEEF);
        preload(16'h0011, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) preload(16'(16'h0040 + i), 32'hB0B00000 + 32'(i));
        preload(16'h00C1, 32'h11111111);

        #1;
        check_val("rst_arready", 32'(arready), 32'd0);
        check_val("rst_awready", 32'(awready), 32'd0);
        check_val("rst_wready",  32'(wready),  32'd0);
        check_val("rst_rvalid",  32'(rvalid),  32'd0);
        check_val("rst_bvalid",  32'(bvalid),  32'd0);
        check_val("rst_rlast",   32'(rlast),   32'd0);
        check_val("rst_ram_en",  32'(ram_en),  32'd0);
        check_val("rst_ram_we",  32'(ram_we),  32'd0);
        check_val("rst_rdata",   rdata,        32'd0);
        check_val("rst_rid",     32'(rid),     32'd0);
        check_val("rst_bid",     32'(bid),     32'd0);
        check_val("rst_bresp",   32'(bresp),   32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // Single read of word 0x10
        send_ar(4'd0, 32'h40, 8'd0, 2'b01);
        recv_r(d, id, last, resp, lat);
        check_val("rd1_data", d, 32'hDEADBEEF);
        check_val("rd1_id",   32'(id),   32'd0);
        check_val("rd1_last", 32'(last), 32'd1);
        check_val("rd1_resp", 32'(resp), 32'd0);
        check_val("rd1_lat_ge3", 32'(lat >= 3), 32'd1);

        // Single write to word 0x11, low half only
        send_aw(4'd1, 32'h44, 8'd0, 2'b01);
        send_w(32'h12345678, 4'b0011, 1'b1);
        recv_b(id, resp);
        check_val("wr1_bid",   32'(id),   32'd1);
        check_val("wr1_bresp", 32'(resp), 32'd0);
        check_val("wr1_mem",   mem[16'h0011], 32'hCAFE5678);
        send_ar(4'd1, 32'h44, 8'd0, 2'b01);
        recv_r(d, id, last, resp, lat);
        check_val("wr1_readback", d, 32'hCAFE5678);

        // INCR burst read of words 0x40..0x43 with rready toggling
        send_ar(4'd2, 32'h100, 8'd3, 2'b01);
        begin
            int beat;
            logic [31:0] held;
            logic held_v;
            beat = 0; held = '0; held_v = 1'b0;
            for (int c = 0; c < 200 && beat < 4; c++) begin
                @(posedge clk); #1;
                rready = (c % 2) == 1;
                #1;
                if (rvalid) begin
                    if (held_v) check_val("burst_stable", rdata, held);
                    if (rready) begin
                        check_val("burst_data", rdata, 32'hB0B00000 + 32'(beat));
                        check_val("burst_rid",  32'(rid), 32'd2);
                        check_val("burst_last", 32'(rlast), 32'(beat == 3));
                        beat++;
                        held_v = 1'b0;
                    end else begin
                        held = rdata;
                        held_v = 1'b1;
                    end
                end
            end
            check_val("burst_beats", 32'(beat), 32'd4);
            @(posedge clk); #1;
            rready = 1'b0;
        end

        // Arbitration: read first, then write, then read again
        do_reset();
        arid = 4'd3; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        awid = 4'd4; awaddr = 32'h48; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
        check_val("arb1_arready", 32'(arready), 32'd1);
        check_val("arb1_awready", 32'(awready), 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        recv_r(d, id, last, resp, lat);
        check_val("arb1_rdata", d, 32'hDEADBEEF);
        arvalid = 1'b1;
        #1;
        check_val("arb2_awready", 32'(awready), 32'd1);
        check_val("arb2_arready", 32'(arready), 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        send_w(32'h0F0F0F0F, 4'hF, 1'b1);
        recv_b(id, resp);
        check_val("arb2_bid", 32'(id), 32'd4);
        check_val("arb2_mem", mem[16'h0012], 32'h0F0F0F0F);
        #1;
        check_val("arb3_arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        recv_r(d, id, last, resp, lat);
        check_val("arb3_rid", 32'(id), 32'd3);

        // wlast asserted early on a two-beat burst
        wc0 = wr_count;
        send_aw(4'd6, 32'h200, 8'd1, 2'b01);
        send_w(32'h11112222, 4'hF, 1'b1);
        send_w(32'h33334444, 4'hF, 1'b1);
        recv_b(id, resp);
        check_val("wlast_bresp",  32'(resp), 32'd2);
        check_val("wlast_writes", 32'(wr_count - wc0), 32'd2);
        check_val("wlast_mem0",   mem[16'h0080], 32'h11112222);
        check_val("wlast_mem1",   mem[16'h0081], 32'h33334444);

        // FIXED burst: both beats land on word 0xC0
        send_aw(4'd7, 32'h300, 8'd1, 2'b00);
        send_w(32'hAAAAAAAA, 4'hF, 1'b0);
        send_w(32'h000000BB, 4'b0001, 1'b1);
        recv_b(id, resp);
        check_val("fixed_bresp", 32'(resp), 32'd0);
        check_val("fixed_mem0",  mem[16'h00C0], 32'hAAAAAABB);
        check_val("fixed_mem1",  mem[16'h00C1], 32'h11111111);

        // Reset during RD_RESP of an eight-beat burst
        send_ar(4'd5, 32'h100, 8'd7, 2'b01);
        rready = 1'b0;
        begin
            int n;
            n = 0;
            #1;
            while (!rvalid && n < 50) begin @(posedge clk); #2; n++; end
            check_val("mid_rvalid", 32'(rvalid), 32'd1);
        end
        resetn = 1'b0;
        #1;
        check_val("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check_val("mid_rst_rdata",  rdata, 32'd0);
        check_val("mid_rst_rid",    32'(rid), 32'd0);
        check_val("mid_rst_ram_en", 32'(ram_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        arid = 4'd9; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        #1;
        check_val("post_rst_arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        recv_r(d, id, last, resp, lat);
        check_val("post_rst_rdata", d, 32'hDEADBEEF);
        check_val("post_rst_rid",   32'(id), 32'd9);
        check_val("post_rst_rlast", 32'(last), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
